// File: rtl/cntr4m_pkg.sv
// -----------------------------------------------------------------------------
// cntr4m_pkg
// Shared definitions for the counter8_4mode block and its slices.
//   - mode_e        : 2-bit operating mode (hold / up / down / load)
//   - CNTR4M_WIDTH  : default counter width
// Optional build macro used by the block: CNTR4M_SATURATE_EN (see top file).
// -----------------------------------------------------------------------------
package cntr4m_pkg;

    localparam int CNTR4M_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : cntr4m_pkg

// File: rtl/counter8_4mode_if.sv
// -----------------------------------------------------------------------------
// counter8_4mode_if
// Bus bundle of the 4-mode counter.
//   B  : parallel-load data            (master -> slave)
//   m  : mode select, see mode_e       (master -> slave)
//   Ci : count enable / carry-in       (master -> slave)
//   Co : carry-out / borrow-out        (slave -> master, combinational)
//   Q  : registered counter value      (slave -> master)
// -----------------------------------------------------------------------------
interface counter8_4mode_if
    import cntr4m_pkg::*;
#(
    parameter int WIDTH = CNTR4M_WIDTH
);

    logic [WIDTH-1:0] B;
    logic [1:0]       m;
    logic             Ci;
    logic             Co;
    logic [WIDTH-1:0] Q;

    modport master (output B, output m, output Ci, input Co, input Q);
    modport slave  (input B, input m, input Ci, output Co, output Q);

endinterface : counter8_4mode_if

// File: rtl/cntr4m_slice.sv
// -----------------------------------------------------------------------------
// cntr4m_slice
// SW-bit 4-mode counter slice (hold / up / down / load), cascadable through
// Ci/Co.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears Q
//   B        : parallel-load data
//   m        : mode select (mode_e encoding)
//   Ci       : count enable / carry-in
//   sat_hold : when high, suppresses up/down steps (used for saturation of the
//              whole cascade; tie low for plain modulo counting)
//   Co       : carry-out in up mode, borrow-out in down mode, combinational
//   Q        : registered slice value
// -----------------------------------------------------------------------------
module cntr4m_slice
    import cntr4m_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] B,
    input  logic [1:0]    m,
    input  logic          Ci,
    input  logic          sat_hold,
    output logic          Co,
    output logic [SW-1:0] Q
);

    localparam logic [SW-1:0] ALL_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] ALL_ONE  = {SW{1'b1}};
    localparam logic [SW-1:0] STEP_ONE = {{(SW-1){1'b0}}, 1'b1};

    mode_e         mode_s;
    logic [SW-1:0] q_r;
    logic [SW-1:0] q_nxt_s;
    logic          co_s;

    assign mode_s = mode_e'(m);

    // Carry/borrow out: terminal count in the active direction with Ci set.
    always_comb begin
        co_s = 1'b0;
        case (mode_s)
            MODE_UP: begin
                co_s = Ci & (q_r == ALL_ONE);
            end
            MODE_DOWN: begin
                co_s = Ci & (q_r == ALL_ZERO);
            end
            MODE_HOLD: begin
                co_s = 1'b0;
            end
            MODE_LOAD: begin
                co_s = 1'b0;
            end
            default: begin
                co_s = 1'b0;
            end
        endcase
    end

    // Next-state value for the counter register.
    always_comb begin
        q_nxt_s = q_r;
        case (mode_s)
            MODE_HOLD: begin
                q_nxt_s = q_r;
            end
            MODE_UP: begin
                if (Ci && !sat_hold) begin
                    q_nxt_s = q_r + STEP_ONE;
                end else begin
                    q_nxt_s = q_r;
                end
            end
            MODE_DOWN: begin
                if (Ci && !sat_hold) begin
                    q_nxt_s = q_r - STEP_ONE;
                end else begin
                    q_nxt_s = q_r;
                end
            end
            MODE_LOAD: begin
                q_nxt_s = B;
            end
            default: begin
                q_nxt_s = q_r;
            end
        endcase
    end

    // Counter register with synchronous reset taking priority over every mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= ALL_ZERO;
        end else begin
            q_r <= q_nxt_s;
        end
    end

    assign Co = co_s;
    assign Q  = q_r;

endmodule : cntr4m_slice

// File: rtl/counter8_4mode.sv
// -----------------------------------------------------------------------------
// counter8_4mode
// WIDTH-bit synchronous up/down counter with hold, count-up, count-down and
// parallel-load modes, built from two WIDTH/2 cntr4m_slice instances chained
// through their carry. WIDTH must be even.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (Q <= 0, priority over all modes)
//   bus : counter8_4mode_if.slave carrying B, m, Ci (in) and Co, Q (out)
// Build option:
//   CNTR4M_SATURATE_EN - when defined, up counting sticks at all-ones and down
//   counting sticks at zero instead of wrapping; Co still flags the
//   overflow/underflow attempt. Undefined (default): modulo wrap-around.
// -----------------------------------------------------------------------------
module counter8_4mode
    import cntr4m_pkg::*;
#(
    parameter int WIDTH = CNTR4M_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    counter8_4mode_if.slave  bus
);

    localparam int HALF = WIDTH / 2;

    logic [HALF-1:0] lo_q_s;
    logic [HALF-1:0] hi_q_s;
    logic            lo_co_s;
    logic            hi_co_s;
    logic            sat_hold_s;

`ifdef CNTR4M_SATURATE_EN
    // Saturation must freeze both slices together: the low slice alone would
    // otherwise keep wrapping while the upper slice is pinned. The top-level Co
    // is exactly the "step would cross the terminal value" condition.
    assign sat_hold_s = hi_co_s;
`else
    assign sat_hold_s = 1'b0;
`endif

    cntr4m_slice #(
        .SW (HALF)
    ) u_lo (
        .clk      (clk),
        .rst      (rst),
        .B        (bus.B[HALF-1:0]),
        .m        (bus.m),
        .Ci       (bus.Ci),
        .sat_hold (sat_hold_s),
        .Co       (lo_co_s),
        .Q        (lo_q_s)
    );

    // The upper slice only steps when the lower slice rolls over.
    cntr4m_slice #(
        .SW (HALF)
    ) u_hi (
        .clk      (clk),
        .rst      (rst),
        .B        (bus.B[WIDTH-1:HALF]),
        .m        (bus.m),
        .Ci       (lo_co_s),
        .sat_hold (sat_hold_s),
        .Co       (hi_co_s),
        .Q        (hi_q_s)
    );

    assign bus.Co = hi_co_s;
    assign bus.Q  = {hi_q_s, lo_q_s};

endmodule : counter8_4mode

// File: tb/tb_counter8_4mode.sv
// -----------------------------------------------------------------------------
// tb_counter8_4mode
// Self-checking bench for counter8_4mode: directed scenarios with literal
// expectations plus a randomized run against an arithmetic reference model.
// Honours CNTR4M_SATURATE_EN in its expectations.
// -----------------------------------------------------------------------------
module tb_counter8_4mode;

    logic clk = 1'b0;
    logic rst = 1'b0;

    counter8_4mode_if #(.WIDTH(8)) bus ();

    counter8_4mode #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_q;       // model counter value
    logic       exp_co;      // model Co for the inputs of the last step, before its edge
    logic       co_seen;     // DUT Co for the same moment

`ifdef CNTR4M_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Reference: value after one edge, from plain integer arithmetic.
    function automatic logic [7:0] ref_next(input logic r, input logic [1:0] mm,
                                            input logic [7:0] bb, input logic c,
                                            input logic [7:0] q);
        int v;
        if (r) return 8'h00;
        case (mm)
            2'b01: begin
                v = int'(q) + (c ? 1 : 0);
                if (v > 255) v = SAT ? 255 : v - 256;
                return v[7:0];
            end
            2'b10: begin
                v = int'(q) - (c ? 1 : 0);
                if (v < 0) v = SAT ? 0 : v + 256;
                return v[7:0];
            end
            2'b11: return bb;
            default: return q;
        endcase
    endfunction

    function automatic logic ref_co(input logic [1:0] mm, input logic c, input logic [7:0] q);
        return (mm == 2'b01 && c && q == 8'hFF) || (mm == 2'b10 && c && q == 8'h00);
    endfunction

    // Apply one cycle of inputs: capture Co before the edge, advance the model.
    task automatic step(input logic r, input logic [1:0] mm, input logic [7:0] bb, input logic c);
        rst    = r;
        bus.m  = mm;
        bus.B  = bb;
        bus.Ci = c;
        #1;
        co_seen = bus.Co;
        exp_co  = ref_co(mm, c, ref_q);
        @(posedge clk);
        ref_q = ref_next(r, mm, bb, c, ref_q);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 2'b01, 8'h00, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'h00) begin n_bad++; $display("FAIL reset_q: got %h want 00", bus.Q); end
        step(1'b0, 2'b11, 8'h00, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'h00) begin n_bad++; $display("FAIL load00_q: got %h want 00", bus.Q); end
        n_cmp++;
        if (bus.Co !== 1'b0) begin n_bad++; $display("FAIL load00_co: got %b want 0", bus.Co); end
    endtask

    task automatic test_load();
        step(1'b0, 2'b11, 8'hB1, 1'b0);
        n_cmp++;
        if (bus.Q !== 8'hB1) begin n_bad++; $display("FAIL load_b1: got %h want b1", bus.Q); end
        step(1'b0, 2'b11, 8'hB1, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'hB1) begin n_bad++; $display("FAIL load_b1_ci: got %h want b1", bus.Q); end
        n_cmp++;
        if (co_seen !== 1'b0) begin n_bad++; $display("FAIL load_co: got %b want 0", co_seen); end
    endtask

    task automatic test_count_up();
        logic [7:0] want;
        step(1'b0, 2'b11, 8'h0E, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, 8'h00, 1'b1);
            want = 8'h0F + 8'(i);
            n_cmp++;
            if (bus.Q !== want) begin n_bad++; $display("FAIL up_step%0d: got %h want %h", i, bus.Q, want); end
        end
        step(1'b0, 2'b01, 8'h00, 1'b0);
        n_cmp++;
        if (bus.Q !== 8'h11) begin n_bad++; $display("FAIL up_ci0_hold: got %h want 11", bus.Q); end
    endtask

    task automatic test_wrap_up();
        step(1'b0, 2'b11, 8'hFF, 1'b0);
        step(1'b0, 2'b01, 8'h00, 1'b1);
        n_cmp++;
        if (co_seen !== 1'b1) begin n_bad++; $display("FAIL up_co_ff: got %b want 1", co_seen); end
        n_cmp++;
        if (bus.Q !== (SAT ? 8'hFF : 8'h00)) begin
            n_bad++; $display("FAIL up_wrap_q: got %h want %h", bus.Q, SAT ? 8'hFF : 8'h00);
        end
        n_cmp++;
        if (bus.Co !== SAT) begin n_bad++; $display("FAIL up_wrap_co_after: got %b want %b", bus.Co, SAT); end
    endtask

    task automatic test_count_down();
        step(1'b0, 2'b11, 8'h10, 1'b0);
        step(1'b0, 2'b10, 8'h00, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'h0F) begin n_bad++; $display("FAIL down_0f: got %h want 0f", bus.Q); end
        step(1'b0, 2'b10, 8'h00, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'h0E) begin n_bad++; $display("FAIL down_0e: got %h want 0e", bus.Q); end
        step(1'b0, 2'b11, 8'h00, 1'b0);
        step(1'b0, 2'b10, 8'h00, 1'b1);
        n_cmp++;
        if (co_seen !== 1'b1) begin n_bad++; $display("FAIL down_borrow: got %b want 1", co_seen); end
        n_cmp++;
        if (bus.Q !== (SAT ? 8'h00 : 8'hFF)) begin
            n_bad++; $display("FAIL down_wrap_q: got %h want %h", bus.Q, SAT ? 8'h00 : 8'hFF);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 2'b11, 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 8'hC3, 1'b1);
            n_cmp++;
            if (bus.Q !== 8'h5A) begin n_bad++; $display("FAIL hold_q%0d: got %h want 5a", i, bus.Q); end
            n_cmp++;
            if (co_seen !== 1'b0) begin n_bad++; $display("FAIL hold_co%0d: got %b want 0", i, co_seen); end
        end
    endtask

    task automatic test_reset_midcount();
        step(1'b0, 2'b11, 8'h33, 1'b0);
        step(1'b0, 2'b01, 8'h00, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'h34) begin n_bad++; $display("FAIL mid_up: got %h want 34", bus.Q); end
        step(1'b1, 2'b01, 8'h00, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'h00) begin n_bad++; $display("FAIL mid_rst: got %h want 00", bus.Q); end
        step(1'b0, 2'b01, 8'h00, 1'b1);
        n_cmp++;
        if (bus.Q !== 8'h01) begin n_bad++; $display("FAIL mid_resume: got %h want 01", bus.Q); end
    endtask

    task automatic test_random();
        logic       r;
        logic [1:0] mm;
        logic [7:0] bb;
        logic       c;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            mm = 2'($urandom_range(0, 3));
            c  = ($urandom_range(0, 3) != 0);
            // Bias loads toward the terminal values and the nibble boundaries.
            case ($urandom_range(0, 5))
                0:       bb = 8'hFF;
                1:       bb = 8'h00;
                2:       bb = 8'h0F;
                3:       bb = 8'hF0;
                default: bb = 8'($urandom_range(0, 255));
            endcase
            step(r, mm, bb, c);
            if (!r) begin
                n_cmp++;
                if (co_seen !== exp_co) begin
                    n_bad++; $display("FAIL rand_co[%0d]: got %b want %b", i, co_seen, exp_co);
                end
            end
            n_cmp++;
            if (bus.Q !== ref_q) begin
                n_bad++; $display("FAIL rand_q[%0d]: got %h want %h", i, bus.Q, ref_q);
            end
        end
    endtask

    initial begin
        bus.B  = 8'h00;
        bus.m  = 2'b00;
        bus.Ci = 1'b0;
        ref_q  = 8'h00;
        test_reset();
        test_load();
        test_count_up();
        test_wrap_up();
        test_count_down();
        test_hold();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_counter8_4mode
